alarm_sequencer: RTL and testbench

ALARM_SEQUENCER -- requirements
Module: alarm_sequencer

---
 rtl/alarm_sequencer.sv | 240 ++++++++++++++++++++++++
 tb/tb_alarm_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/alarm_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alarm_sequencer
// Brief    : Frame-timed burglar/fire alarm sequencer. It synchronises the
//            raw switch inputs, runs the exit/entry delays and latches the
//            alarm cause. It also produces a flashing display colour.
// Options  : ALARM_FLASH_EN - when defined, colours flash with a half-period
//            of FLASH_FRAMES frames; otherwise colours are steady.
// Revision : 1.0 - initial release
// ============================================================================
module alarm_sequencer #(
    parameter int EXIT_FRAMES  = 120,
    parameter int ENTRY_FRAMES = 60,
    parameter int FLASH_FRAMES = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       sw_armed,
    input  logic       sw_door,
    input  logic       sw_window,
    input  logic       sw_motion,
    input  logic       sw_temp,
    input  logic       sw_clear,
    output logic [2:0] state,
    output logic [1:0] cause,
    output logic [7:0] countdown,
    output logic [5:0] color
);

    localparam logic [2:0] c_ST_DISARMED = 3'd0;
    localparam logic [2:0] c_ST_EXIT     = 3'd1;
    localparam logic [2:0] c_ST_ARMED    = 3'd2;
    localparam logic [2:0] c_ST_ENTRY    = 3'd3;
    localparam logic [2:0] c_ST_ALARM    = 3'd4;

    localparam logic [1:0] c_CAUSE_NONE      = 2'd0;
    localparam logic [1:0] c_CAUSE_INTRUSION = 2'd1;
    localparam logic [1:0] c_CAUSE_WINDOW    = 2'd2;
    localparam logic [1:0] c_CAUSE_TEMP      = 2'd3;

    localparam logic [7:0] c_EXIT_LOAD  = 8'(EXIT_FRAMES);
    localparam logic [7:0] c_ENTRY_LOAD = 8'(ENTRY_FRAMES);

    // Bit order {clear, temp, motion, window, door, armed}
    logic [5:0] r_sync_q1;
    logic [5:0] r_sync_q2;
    logic       r_clear_prev;

    logic [2:0] r_state;
    logic [1:0] r_cause;
    logic [7:0] r_countdown;
    logic [5:0] r_color;

    logic [2:0] w_next_state;
    logic [1:0] w_next_cause;
    logic [7:0] w_next_countdown;
    logic       w_state_change;
    logic       w_phase;

    logic w_armed, w_door, w_window, w_motion, w_temp, w_clear_rise;

    // Two-flop synchroniser for the switch levels, plus clear edge history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_q1    <= '0;
            r_sync_q2    <= '0;
            r_clear_prev <= 1'b0;
        end else begin
            r_sync_q1    <= {sw_clear, sw_temp, sw_motion, sw_window, sw_door, sw_armed};
            r_sync_q2    <= r_sync_q1;
            r_clear_prev <= r_sync_q2[5];
        end
    end

    assign w_armed      = r_sync_q2[0];
    assign w_door       = r_sync_q2[1];
    assign w_window     = r_sync_q2[2];
    assign w_motion     = r_sync_q2[3];
    assign w_temp       = r_sync_q2[4];
    assign w_clear_rise = r_sync_q2[5] & ~r_clear_prev;

    // Next-state logic; event priority is temp > window > disarm > expiry > door/motion
    always_comb begin
        w_next_state     = r_state;
        w_next_cause     = r_cause;
        w_next_countdown = r_countdown;
        if (w_temp && (r_state != c_ST_ALARM)) begin
            w_next_state     = c_ST_ALARM;
            w_next_cause     = c_CAUSE_TEMP;
            w_next_countdown = 8'd0;
        end else begin
            case (r_state)
                c_ST_DISARMED: begin
                    if (w_armed) begin
                        w_next_state     = c_ST_EXIT;
                        w_next_countdown = c_EXIT_LOAD;
                    end
                end
                c_ST_EXIT: begin
                    if (!w_armed) begin
                        w_next_state     = c_ST_DISARMED;
                        w_next_countdown = 8'd0;
                    end else if (frame_tick) begin
                        // A zero load expires on the first tick, like a load of one
                        if (r_countdown <= 8'd1) begin
                            w_next_state     = c_ST_ARMED;
                            w_next_countdown = 8'd0;
                        end else begin
                            w_next_countdown = r_countdown - 8'd1;
                        end
                    end
                end
                c_ST_ARMED: begin
                    if (w_window) begin
                        w_next_state = c_ST_ALARM;
                        w_next_cause = c_CAUSE_WINDOW;
                    end else if (!w_armed) begin
                        w_next_state = c_ST_DISARMED;
                    end else if (w_door || w_motion) begin
                        w_next_state     = c_ST_ENTRY;
                        w_next_countdown = c_ENTRY_LOAD;
                    end
                end
                c_ST_ENTRY: begin
                    if (w_window) begin
                        w_next_state     = c_ST_ALARM;
                        w_next_cause     = c_CAUSE_WINDOW;
                        w_next_countdown = 8'd0;
                    end else if (!w_armed) begin
                        w_next_state     = c_ST_DISARMED;
                        w_next_countdown = 8'd0;
                    end else if (frame_tick) begin
                        if (r_countdown <= 8'd1) begin
                            w_next_state     = c_ST_ALARM;
                            w_next_cause     = c_CAUSE_INTRUSION;
                            w_next_countdown = 8'd0;
                        end else begin
                            w_next_countdown = r_countdown - 8'd1;
                        end
                    end
                end
                c_ST_ALARM: begin
                    // Temperature always wins the cause; otherwise the cause is frozen
                    if (w_temp) begin
                        w_next_cause = c_CAUSE_TEMP;
                    end else if (w_clear_rise && !w_armed) begin
                        w_next_state = c_ST_DISARMED;
                        w_next_cause = c_CAUSE_NONE;
                    end
                end
                default: begin
                    w_next_state     = c_ST_DISARMED;
                    w_next_cause     = c_CAUSE_NONE;
                    w_next_countdown = 8'd0;
                end
            endcase
        end
    end

    assign w_state_change = (w_next_state != r_state);

    // State, cause and countdown registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_DISARMED;
            r_cause     <= c_CAUSE_NONE;
            r_countdown <= 8'd0;
        end else begin
            r_state     <= w_next_state;
            r_cause     <= w_next_cause;
            r_countdown <= w_next_countdown;
        end
    end

`ifdef ALARM_FLASH_EN
    localparam int c_FLASH_W = (FLASH_FRAMES > 2) ? $clog2(FLASH_FRAMES) : 1;
    localparam logic [c_FLASH_W-1:0] c_FLASH_LAST =
        (FLASH_FRAMES > 1) ? c_FLASH_W'(FLASH_FRAMES - 1) : '0;

    logic [c_FLASH_W-1:0] r_flash_cnt;
    logic                 r_phase;

    // Flash half-period counter; restarts in the on phase whenever the state moves
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flash_cnt <= '0;
            r_phase     <= 1'b1;
        end else if (w_state_change) begin
            r_flash_cnt <= '0;
            r_phase     <= 1'b1;
        end else if (frame_tick) begin
            if (r_flash_cnt >= c_FLASH_LAST) begin
                r_flash_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_flash_cnt <= r_flash_cnt + 1'b1;
            end
        end
    end

    assign w_phase = r_phase;
`else
    // Steady colours: the phase is a constant and FLASH_FRAMES only keeps its place
    assign w_phase = (FLASH_FRAMES != 0) | 1'b1;
`endif

    // Display colour, registered one cycle behind state and flash phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_color <= 6'b000000;
        end else begin
            case (r_state)
                c_ST_EXIT:  r_color <= w_phase ? 6'b001100 : 6'b000000;
                c_ST_ARMED: r_color <= 6'b000001;
                c_ST_ENTRY: r_color <= w_phase ? 6'b110000 : 6'b000000;
                c_ST_ALARM: begin
                    if (!w_phase) begin
                        r_color <= 6'b000000;
                    end else begin
                        case (r_cause)
                            c_CAUSE_TEMP:      r_color <= 6'b111111;
                            c_CAUSE_WINDOW:    r_color <= 6'b111100;
                            c_CAUSE_INTRUSION: r_color <= 6'b110011;
                            default:           r_color <= 6'b000000;
                        endcase
                    end
                end
                default:    r_color <= 6'b000000;
            endcase
        end
    end

    assign state     = r_state;
    assign cause     = r_cause;
    assign countdown = r_countdown;
    assign color     = r_color;

endmodule
`default_nettype wire

// File: tb/tb_alarm_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alarm_sequencer
// Brief    : Scoreboard bench for alarm_sequencer (EXIT=4, ENTRY=3, FLASH=2).
//            Works with or without ALARM_FLASH_EN defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alarm_sequencer;

`ifdef ALARM_FLASH_EN
    localparam bit FLASH = 1'b1;
`else
    localparam bit FLASH = 1'b0;
`endif

    localparam logic [5:0] COL_EXIT   = 6'b001100;
    localparam logic [5:0] COL_ARMED  = 6'b000001;
    localparam logic [5:0] COL_ENTRY  = 6'b110000;
    localparam logic [5:0] COL_INTR   = 6'b110011;
    localparam logic [5:0] COL_WINDOW = 6'b111100;
    localparam logic [5:0] COL_TEMP   = 6'b111111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_tick;
    logic       sw_armed, sw_door, sw_window, sw_motion, sw_temp, sw_clear;
    logic [2:0] state;
    logic [1:0] cause;
    logic [7:0] countdown;
    logic [5:0] color;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        string      name;
        logic [2:0] st;
        logic [1:0] cs;
        logic [7:0] cd;
        logic [5:0] col;
    } exp_t;

    exp_t q[$];

    alarm_sequencer #(
        .EXIT_FRAMES (4),
        .ENTRY_FRAMES(3),
        .FLASH_FRAMES(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .frame_tick(frame_tick),
        .sw_armed  (sw_armed),
        .sw_door   (sw_door),
        .sw_window (sw_window),
        .sw_motion (sw_motion),
        .sw_temp   (sw_temp),
        .sw_clear  (sw_clear),
        .state     (state),
        .cause     (cause),
        .countdown (countdown),
        .color     (color)
    );

    always #5 clk = ~clk;

    // Colour expected while the flash phase is off (only differs when flashing)
    function automatic logic [5:0] off_col(input logic [5:0] c);
        return FLASH ? 6'b000000 : c;
    endfunction

    // Monitor: pops one expectation per falling edge and compares outputs
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            n_total++;
            if (state === e.st && cause === e.cs && countdown === e.cd && color === e.col) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got state=%0d cause=%0d countdown=%0d color=%b, expected state=%0d cause=%0d countdown=%0d color=%b",
                         e.name, state, cause, countdown, color, e.st, e.cs, e.cd, e.col);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
    endtask

    // Tick, then wait one more cycle for the registered colour to follow
    task automatic tick_settle();
        tick();
        cyc(1);
    endtask

    task automatic chk(input string name, input logic [2:0] st, input logic [1:0] cs,
                       input logic [7:0] cd, input logic [5:0] col);
        exp_t e;
        e.name = name;
        e.st   = st;
        e.cs   = cs;
        e.cd   = cd;
        e.col  = col;
        q.push_back(e);
        for (int i = 0; i < 20 && q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (q.size() != 0) begin
            n_total++;
            $display("FAIL %s: monitor never consumed the expectation (got none, expected a sample)", name);
            q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        frame_tick = 1'b0;
        sw_armed = 1'b0; sw_door = 1'b0; sw_window = 1'b0;
        sw_motion = 1'b0; sw_temp = 1'b0; sw_clear = 1'b0;

        chk("reset", 3'd0, 2'd0, 8'd0, 6'b000000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(2);

        // Arm and run the exit delay
        sw_armed = 1'b1;
        cyc(4);
        chk("exit_load", 3'd1, 2'd0, 8'd4, COL_EXIT);
        tick_settle(); chk("exit_cd3", 3'd1, 2'd0, 8'd3, COL_EXIT);
        tick_settle(); chk("exit_cd2", 3'd1, 2'd0, 8'd2, off_col(COL_EXIT));
        tick_settle(); chk("exit_cd1", 3'd1, 2'd0, 8'd1, off_col(COL_EXIT));
        tick_settle(); chk("armed", 3'd2, 2'd0, 8'd0, COL_ARMED);

        // Door pulse, entry delay expires into intrusion alarm
        sw_door = 1'b1; cyc(1); sw_door = 1'b0;
        cyc(3);
        chk("entry_load", 3'd3, 2'd0, 8'd3, COL_ENTRY);
        tick_settle(); chk("entry_cd2", 3'd3, 2'd0, 8'd2, COL_ENTRY);
        tick_settle(); chk("entry_cd1", 3'd3, 2'd0, 8'd1, off_col(COL_ENTRY));
        tick_settle(); chk("alarm_intr", 3'd4, 2'd1, 8'd0, COL_INTR);

        // Flash cadence in alarm
        tick_settle(); chk("flash_t1", 3'd4, 2'd1, 8'd0, COL_INTR);
        tick_settle(); chk("flash_t2", 3'd4, 2'd1, 8'd0, off_col(COL_INTR));
        tick_settle(); chk("flash_t3", 3'd4, 2'd1, 8'd0, off_col(COL_INTR));
        tick_settle(); chk("flash_t4", 3'd4, 2'd1, 8'd0, COL_INTR);

        // Short reset pulse between clock edges clears everything at once
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        chk("rst_async", 3'd0, 2'd0, 8'd0, 6'b000000);
        cyc(4);
        chk("exit_restart", 3'd1, 2'd0, 8'd4, COL_EXIT);

        // Disarm during entry delay
        repeat (4) tick();
        cyc(1);
        sw_door = 1'b1; cyc(1); sw_door = 1'b0;
        cyc(3);
        tick_settle(); chk("entry2_cd2", 3'd3, 2'd0, 8'd2, COL_ENTRY);
        sw_armed = 1'b0;
        cyc(4);
        chk("entry_disarm", 3'd0, 2'd0, 8'd0, 6'b000000);

        // Temperature alarm from disarmed, clear gating
        sw_temp = 1'b1;
        cyc(4);
        chk("temp_alarm", 3'd4, 2'd3, 8'd0, COL_TEMP);
        sw_clear = 1'b1;
        cyc(4);
        chk("clear_ignored", 3'd4, 2'd3, 8'd0, COL_TEMP);
        sw_clear = 1'b0; sw_temp = 1'b0;
        cyc(4);
        chk("temp_hold", 3'd4, 2'd3, 8'd0, COL_TEMP);
        sw_clear = 1'b1;
        cyc(4);
        chk("clear_edge", 3'd0, 2'd0, 8'd0, 6'b000000);
        sw_clear = 1'b0;
        cyc(2);

        // Window wins over simultaneous disarm, then temp upgrades cause
        sw_armed = 1'b1;
        cyc(4);
        repeat (4) tick();
        cyc(1);
        chk("armed2", 3'd2, 2'd0, 8'd0, COL_ARMED);
        sw_window = 1'b1; sw_armed = 1'b0;
        cyc(4);
        chk("window_alarm", 3'd4, 2'd2, 8'd0, COL_WINDOW);
        sw_temp = 1'b1;
        cyc(4);
        chk("temp_upgrade", 3'd4, 2'd3, 8'd0, COL_TEMP);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
